// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory initiator: access sizes, FSM states and the
// byte-lane position helper used by both the lane unit and the top.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // Bit position of the lowest bit of the addressed lane within the word.
    // Big-endian mirrors the lane index: byte 3-offset, half 2-offset.
    function automatic logic [4:0] lane_shift(input logic [1:0] offset,
                                              input logic [1:0] size,
                                              input logic       big_endian);
        logic [1:0] lane_idx;
        lane_idx = 2'b00;
        if (size == SZ_BYTE)
            lane_idx = big_endian ? ~offset : offset;
        else if (size == SZ_HALF)
            lane_idx = big_endian ? {~offset[1], 1'b0} : {offset[1], 1'b0};
        return {lane_idx, 3'b000};
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: merges store data into a fetched word and extracts
// plus sign/zero-extends the addressed lane of a loaded word.
module byte_lane_unit
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] extracted
);

    logic [4:0]        shift;
    logic [WORD_W-1:0] lane_mask;
    logic [WORD_W-1:0] lane;

    always_comb begin
        shift     = lane_shift(offset, size, BIG_ENDIAN);
        lane_mask = (size == SZ_BYTE) ? 32'h0000_00FF :
                    (size == SZ_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        merged    = (word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
        lane      = (word >> shift) & lane_mask;
        extracted = lane;
        if (is_signed && size == SZ_BYTE && lane[7])
            extracted = lane | 32'hFFFF_FF00;
        else if (is_signed && size == SZ_HALF && lane[15])
            extracted = lane | 32'hFFFF_0000;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the word-only data memory: loads, word stores and sub-word
// read-modify-write stores, with alignment/range checking and a one-cycle response.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS  = 2048,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WORD_W-1:0] mem_readdata,
    output state_t            dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and the response is a single
    // resp_valid cycle with no back-pressure, never overlapping req_ready.
    state_t            state, state_next;
    logic [WORD_W-1:0] addr_q, wdata_q, word_q;
    logic [1:0]        size_q;
    logic              signed_q, write_q, err_q;
    logic              accept, req_err;
    logic [WORD_W-1:0] merged, extracted;

    assign accept    = req_valid && (state == IDLE) && !rst;
    assign dbg_state = state;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
            req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                err_q    <= req_err;
            end
            if (state == RD)
                word_q <= mem_readdata;
        end
    end

    // Every output is held at its idle value while rst is high, which also
    // suppresses a write that would otherwise land in the reset cycle.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_rdata    = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (req_err)
                            state_next = RESP;
                        else if (req_write && req_size == SZ_WORD)
                            state_next = WR;
                        else
                            state_next = RD;
                    end
                end
                RD: begin
                    mem_read    = 1'b1;
                    mem_address = {addr_q[31:2], 2'b00};
                    state_next  = write_q ? WR : RESP;
                end
                WR: begin
                    mem_write     = 1'b1;
                    mem_address   = {addr_q[31:2], 2'b00};
                    mem_writedata = merged;
                    state_next    = RESP;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                    if (!write_q && !err_q)
                        resp_rdata = extracted;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Word stores pass through the merge unchanged (full-width lane mask).
    byte_lane_unit #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lanes (
        .word      (word_q),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .extracted (extracted)
    );

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory of the multicycle MIPS core.
- Accepts one load or store request from the datapath, with byte, half or word size, and drives the memory's address, writedata, memRead and memWrite pins.
- The memory can only read and write whole words, so sub-word stores use read-modify-write.
- Performs sign or zero extension on loads, detects misaligned and out-of-range accesses, and returns a one-cycle response pulse.

Parameters:
- MEM_WORDS, 2048, number of 32-bit words in the attached memory. A word index >= MEM_WORDS is out of range.
- BIG_ENDIAN, 0, byte lane order. 0: byte offset 0 maps to bits [7:0]. 1: byte offset 0 maps to bits [31:24].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load result (ignored for word and for stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size or out of range; qualified by resp_valid
- mem_address  out  32  byte address to memory, always word-aligned ([1:0]=00)
- mem_writedata  out  32  full word to write
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable; memory writes on the rising edge while high
- mem_readdata  in  32  combinational memory read data, valid in the same cycle as mem_read

Behaviour:
- Reset values:
  - state IDLE.
  - req_ready=1 once out of reset; 0 while rst is high.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, size, signed, write and wdata.
  - Error check at accept:
    - size 11 -> error.
    - half with addr[0]=1 -> error.
    - word with addr[1:0]!=00 -> error.
    - addr[31:2] >= MEM_WORDS -> error.
  - Next state:
    - error -> RESP with err flag set, no memory access.
    - load -> RD.
    - word store -> WR.
    - byte/half store -> RD.
- RD:
  - mem_read=1, mem_address={addr[31:2],2'b00}.
  - mem_readdata is captured into the word register at the clock edge.
  - Next: load -> RESP; sub-word store -> WR.
- WR:
  - mem_write=1, mem_address as in RD.
  - mem_writedata:
    - word store: req_wdata.
    - sub-word store: captured word with only the addressed byte/half lanes replaced by req_wdata[7:0] / [15:0].
  - Next: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0.
  - Load: resp_rdata is the selected lane, sign- or zero-extended (word: unchanged).
  - Store or error: resp_rdata=0.
  - Next: IDLE. A new request can be accepted in the cycle after RESP.
- Latency, from the accept edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- mem_read and mem_write are never both high. Both are 0 outside RD/WR.
- mem_write is gated by ~rst: a reset asserted during WR suppresses the write in that same cycle.
- Reset in any state returns to IDLE at the next edge. No response is issued for the aborted request.
- Latched request fields are held stable from accept through RESP. Input changes after accept are ignored.
- resp_valid and req_ready are never both high.

Decomposition:
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum (IDLE, RD, WR, RESP).
  - WORD_W=32.
- Sub-module byte_lane_unit: purely combinational.
  - Merge: given word, offset, size, wdata and endianness, produces the merged write word.
  - Extract: given word, offset, size, signed and endianness, produces the extended load value.
  - The FSM and registers stay in mem_access_unit.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF.
  - mem_write is high one cycle with mem_address=0x10 and resp_valid 2 cycles after accept.
  - A load from 0x10 returns 0xDEADBEEF 2 cycles after its accept.
- Byte RMW, little-endian: memory[0x20]=0x11223344; store byte 0xAA to addr 0x21.
  - mem_read high in cycle 1, mem_write in cycle 2 with writedata 0x1122AA44.
  - resp_valid in cycle 3.
- Signed and unsigned loads from word 0x80FF7F01:
  - byte at offset 1, signed -> 0x0000007F.
  - byte at offset 2, signed -> 0xFFFFFFFF.
  - half at offset 2, unsigned -> 0x000080FF.
  - half at offset 2, signed -> 0xFFFF80FF.
- Errors:
  - word load at 0x06 -> resp_err=1 one cycle after accept, rdata 0, mem_read/mem_write never high.
  - half at 0x03 -> same as above.
  - size 11 -> same as above.
  - address 0x2000 (word 2048) -> same as above.
- Reset mid-operation: assert rst during the WR cycle of a byte store.
  - mem_write is 0 in that cycle and the memory word is unchanged.
  - Next cycle: state IDLE, req_ready=1, no resp_valid.
- Back-to-back handshake: hold req_valid high across two requests.
  - Second request is accepted only in the cycle after the first resp_valid.
  - req_ready is low throughout RD/WR/RESP.
